// File: rtl/multu_unit_pkg.sv
// multu_unit_pkg: shared decode constants and FSM state type for the
// iterative MULTU unit and its HI/LO writeback path.
package multu_unit_pkg;

  localparam logic [2:0] ALU_MULTU   = 3'b100;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/multu_unit_if.sv
// multu_unit_if: decoder/PC/writeback-facing signals of the multiplier.
//   start       decoded MULTU this cycle
//   srca, srcb  multiplicand (rs) / multiplier (rt)
//   busy        multiply in progress
//   stall       hold PC and suppress regwrite
//   done        one-cycle pulse, HI/LO just updated
//   hi, lo      architectural HI/LO registers
// master = decoder side (drives start/operands), slave = multiplier.
interface multu_unit_if;
  logic        start;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, srca, srcb,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, srca, srcb,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/multu_unit_step.sv
// multu_step: one combinational retire step of the iterative multiplier.
//   acc_i    running 64-bit accumulator
//   mcand_i  32-bit multiplicand
//   bits_i   low BITS_PER_CYCLE bits of the multiplier shift register
//   shift_i  bit position of bits_i within the original multiplier
//   acc_o    acc_i + (mcand_i * bits_i) << shift_i, unsigned
module multu_step #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [63:0]               acc_i,
  input  logic [31:0]               mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  input  logic [5:0]                shift_i,
  output logic [63:0]               acc_o
);

  logic [63:0] mcand_ext;
  logic [63:0] bits_ext;
  logic [63:0] pp;

  always_comb begin
    mcand_ext = {32'b0, mcand_i};
    bits_ext  = {{(64-BITS_PER_CYCLE){1'b0}}, bits_i};
    pp        = mcand_ext * bits_ext;
    acc_o     = acc_i + (pp << shift_i);
  end

endmodule

// File: rtl/multu_unit.sv
// multu_unit: iterative unsigned 32x32 multiplier with HI/LO registers.
//   clk    system clock, rising edge
//   reset  asynchronous active-high, clears all state
//   bus    multu_unit_if.slave: start/srca/srcb in; busy/stall/done/hi/lo out
// A multiply takes 32/BITS_PER_CYCLE RUN cycles; HI/LO update atomically
// on the last one and done pulses for the following cycle.
module multu_unit
  import multu_unit_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned WIDTH          = 32
) (
  input  logic         clk,
  input  logic         reset,
  multu_unit_if.slave  bus
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic [5:0]           shift;
  logic [2*WIDTH-1:0]   acc_next;

  assign shift = 6'(count_q * BITS_PER_CYCLE);

  multu_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BITS_PER_CYCLE-1:0]),
    .shift_i (shift),
    .acc_o   (acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.srca;
          mplier_d = bus.srcb;
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_next;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        count_d  = count_q + 1'b1;
        // Final step writes HI/LO straight from the adder output so the
        // result lands in the same edge that leaves RUN.
        if (count_q == CW'(N - 1)) begin
          hi_d    = acc_next[2*WIDTH-1:WIDTH];
          lo_d    = acc_next[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.stall = bus.busy | (bus.start & ~bus.busy);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: directed checks of multu_unit at BITS_PER_CYCLE=1 and 4.
module tb_multu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sel;
  logic [31:0] srca;
  logic [31:0] srcb;

  logic        obs_busy, obs_stall, obs_done;
  logic [31:0] obs_hi, obs_lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multu_unit_if if1 ();
  multu_unit_if if4 ();

  assign if1.start = start & ~sel;
  assign if1.srca  = srca;
  assign if1.srcb  = srcb;
  assign if4.start = start & sel;
  assign if4.srca  = srca;
  assign if4.srcb  = srcb;

  multu_unit #(.BITS_PER_CYCLE(1), .WIDTH(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  multu_unit #(.BITS_PER_CYCLE(4), .WIDTH(32)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4)
  );

  always_comb begin
    obs_busy  = sel ? if4.busy  : if1.busy;
    obs_stall = sel ? if4.stall : if1.stall;
    obs_done  = sel ? if4.done  : if1.done;
    obs_hi    = sel ? if4.hi    : if1.hi;
    obs_lo    = sel ? if4.lo    : if1.lo;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of the first RUN cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input string tag);
    srca  = a;
    srcb  = b;
    start = 1'b1;
    #1;
    check({tag, "_stall_at_start"}, obs_stall, 1);
    check({tag, "_idle_at_start"}, obs_busy, 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walks the n RUN cycles, then checks the done cycle; returns in the done cycle.
  task automatic run_check(input int n, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic [31:0] phi, input logic [31:0] plo,
                           input bit scramble, input bit midpulse, input string tag);
    int bad = 0;
    for (int i = 1; i <= n; i++) begin
      if (obs_busy !== 1'b1 || obs_stall !== 1'b1 || obs_done !== 1'b0 ||
          obs_hi !== phi || obs_lo !== plo)
        bad++;
      if (scramble) begin
        srca = $urandom;
        srcb = $urandom;
      end
      if (midpulse && i == n / 2) begin
        srca  = 32'd5;
        srcb  = 32'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_run_bad_cycles"}, 64'(bad), 0);
    check({tag, "_done"}, obs_done, 1);
    check({tag, "_busy_end"}, obs_busy, 0);
    check({tag, "_hi"}, obs_hi, ehi);
    check({tag, "_lo"}, obs_lo, elo);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    sel   = 1'b0;
    start = 1'b0;
    srca  = '0;
    srcb  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy1", if1.busy, 0);
    check("rst_stall1", if1.stall, 0);
    check("rst_done1", if1.done, 0);
    check("rst_hilo1", {if1.hi, if1.lo}, 0);
    check("rst_busy4", if4.busy, 0);
    check("rst_hilo4", {if4.hi, if4.lo}, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    run_check(32, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0, 32'h0, 1'b0, 1'b0, "max");
    @(negedge clk);
    check("max_done_falls", obs_done, 0);

    issue(32'h1234_5678, 32'h9ABC_DEF0, "mix");
    run_check(32, 32'h0B00_EA4E, 32'h242D_2080, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "mix");
    @(negedge clk);

    issue(32'd7, 32'd9, "rstrun");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstrun_busy", obs_busy, 0);
    check("rstrun_stall", obs_stall, 0);
    check("rstrun_hi", obs_hi, 0);
    check("rstrun_lo", obs_lo, 0);
    @(negedge clk);
    reset = 1'b0;
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (obs_done !== 1'b0) dc++;
    end
    check("rstrun_no_done", 64'(dc), 0);

    issue(32'd7, 32'd9, "m7x9");
    run_check(32, 32'h0, 32'd63, 32'h0, 32'h0, 1'b0, 1'b0, "m7x9");
    @(negedge clk);

    issue(32'h0, 32'hDEAD_BEEF, "zero");
    run_check(32, 32'h0, 32'h0, 32'h0, 32'd63, 1'b0, 1'b0, "zero");
    @(negedge clk);

    issue(32'd3, 32'd5, "b2b_a");
    run_check(32, 32'h0, 32'd15, 32'h0, 32'h0, 1'b0, 1'b0, "b2b_a");
    issue(32'h0001_0000, 32'h0001_0000, "b2b_b");
    check("b2b_done_falls", obs_done, 0);
    check("b2b_busy_rises", obs_busy, 1);
    run_check(32, 32'h1, 32'h0, 32'h0, 32'd15, 1'b0, 1'b1, "b2b_b");
    @(negedge clk);

    issue(32'h8000_0000, 32'h8000_0000, "iso");
    run_check(32, 32'h4000_0000, 32'h0, 32'h1, 32'h0, 1'b1, 1'b0, "iso");
    @(negedge clk);

    sel = 1'b1;
    #1;
    check("bpc4_idle_hilo", {obs_hi, obs_lo}, 0);
    issue(32'hFFFF_FFFF, 32'd2, "bpc4");
    run_check(8, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0, 1'b0, "bpc4");
    @(negedge clk);
    check("bpc4_done_falls", obs_done, 0);
    check("bpc4_stall_off", obs_stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
